// File: rtl/pit_share_sequencer.sv
// Round-robin owner of the shared interval timer: reloads it with the winner's settings
// over the byte-wide write port and routes timer interrupts back as per-owner done pulses.
module pit_share_sequencer #(
    parameter int NUM_REQ     = 4,
    parameter int CFG_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_count,
    input  logic [NUM_REQ-1:0]     req_divider,
    input  logic [NUM_REQ-1:0]     req_repeat,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   cfg_err,
    output logic                   busy,
    output logic                   timer_rst,
    output logic                   timer_we,
    output logic [1:0]             timer_addr,
    output logic [7:0]             timer_data,
    input  logic                   timer_irq,
    input  logic                   timer_counter_set
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(CFG_TIMEOUT + 1);
    localparam logic [TW-1:0] TO = TW'(CFG_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WR_CFG, S_WR_HI, S_WR_LO, S_WAIT_SET, S_ARMED, S_RELEASE
    } state_t;

    state_t             r_state, w_next;
    logic [PW-1:0]      r_ptr, w_ptr_next, r_owner, w_owner_next, w_sel;
    logic               w_found;
    logic [15:0]        r_count;
    logic               r_div, r_rep;
    logic [TW-1:0]      r_tcnt, w_tcnt_next;
    logic [NUM_REQ-1:0] r_grant, w_grant, r_done, w_done;
    logic               r_cfg_err, w_cfg_err, r_busy, r_timer_rst, w_rst, r_timer_we, w_we;
    logic [1:0]         r_addr, w_addr;
    logic [7:0]         r_data, w_data;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(off);
        if (s >= (PW+1)'(NUM_REQ)) s = s - (PW+1)'(NUM_REQ);
        return s[PW-1:0];
    endfunction

    // First requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[wrap_add(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_add(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        w_tcnt_next  = r_tcnt;
        w_done       = '0;
        w_cfg_err    = 1'b0;
        case (r_state)
            S_IDLE: if (w_found) begin
                w_next       = S_CLEAR;
                w_owner_next = w_sel;
            end
            S_CLEAR:  w_next = S_WR_CFG;
            S_WR_CFG: w_next = S_WR_HI;
            S_WR_HI:  w_next = S_WR_LO;
            S_WR_LO: begin
                w_next      = S_WAIT_SET;
                w_tcnt_next = '0;
            end
            S_WAIT_SET: if (timer_counter_set) begin
                w_next = S_ARMED;
            end else begin
                w_tcnt_next = r_tcnt + 1'b1;
                if (r_tcnt + 1'b1 == TO) begin
                    w_cfg_err = 1'b1;
                    w_next    = S_RELEASE;
                end
            end
            S_ARMED: if (timer_irq) begin
                w_done = NUM_REQ'(1) << r_owner;
                if (!r_rep) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                w_ptr_next = wrap_add(r_owner, 1);
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Owner withdrawal aborts the load; a same-cycle irq still yields its done pulse.
        if (r_state != S_IDLE && r_state != S_RELEASE && !req[r_owner]) begin
            w_next    = S_RELEASE;
            w_cfg_err = 1'b0;
        end

        w_rst  = (w_next == S_CLEAR) || (w_next == S_RELEASE);
        w_we   = 1'b0;
        w_addr = 2'b00;
        w_data = 8'h00;
        case (w_next)
            S_WR_CFG: begin w_we = 1'b1; w_addr = 2'b00; w_data = {r_div, r_rep, 6'b0}; end
            S_WR_HI:  begin w_we = 1'b1; w_addr = 2'b01; w_data = r_count[15:8];       end
            S_WR_LO:  begin w_we = 1'b1; w_addr = 2'b10; w_data = r_count[7:0];        end
            default:  ;
        endcase
        w_grant = (w_next == S_IDLE || w_next == S_RELEASE) ? '0 : (NUM_REQ'(1) << w_owner_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_count     <= '0;
            r_div       <= 1'b0;
            r_rep       <= 1'b0;
            r_tcnt      <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_timer_rst <= 1'b0;
            r_timer_we  <= 1'b0;
            r_addr      <= 2'b00;
            r_data      <= 8'h00;
        end else begin
            r_state     <= w_next;
            r_ptr       <= w_ptr_next;
            r_owner     <= w_owner_next;
            r_tcnt      <= w_tcnt_next;
            r_grant     <= w_grant;
            r_done      <= w_done;
            r_cfg_err   <= w_cfg_err;
            r_busy      <= (w_next != S_IDLE);
            r_timer_rst <= w_rst;
            r_timer_we  <= w_we;
            r_addr      <= w_addr;
            r_data      <= w_data;
            if (r_state == S_IDLE && w_found) begin
                r_count <= req_count[16*w_sel +: 16];
                r_div   <= req_divider[w_sel];
                r_rep   <= req_repeat[w_sel];
            end
        end
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign busy       = r_busy;
    assign timer_rst  = r_timer_rst;
    assign timer_we   = r_timer_we;
    assign timer_addr = r_addr;
    assign timer_data = r_data;
endmodule

// File: tb/tb_pit_share_sequencer.sv
// Scoreboard bench for pit_share_sequencer with a behavioural timer model.
module tb_pit_share_sequencer;
    localparam int N  = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, req_divider, req_repeat, grant, done;
    logic [16*N-1:0] req_count;
    logic          cfg_err, busy, timer_rst, timer_we, timer_irq, timer_counter_set;
    logic [1:0]    timer_addr;
    logic [7:0]    timer_data;

    pit_share_sequencer #(.NUM_REQ(N), .CFG_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_count(req_count),
        .req_divider(req_divider), .req_repeat(req_repeat), .grant(grant), .done(done),
        .cfg_err(cfg_err), .busy(busy), .timer_rst(timer_rst), .timer_we(timer_we),
        .timer_addr(timer_addr), .timer_data(timer_data), .timer_irq(timer_irq),
        .timer_counter_set(timer_counter_set)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0]   exp_wr[$];
    logic [N-1:0] exp_grant[$];
    logic [N-1:0] exp_done[$];
    bit           exp_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_load(input logic [N-1:0] g, input logic [7:0] cfg, input logic [15:0] cnt);
        exp_grant.push_back(g);
        exp_wr.push_back({2'b00, cfg});
        exp_wr.push_back({2'b01, cnt[15:8]});
        exp_wr.push_back({2'b10, cnt[7:0]});
    endtask

    // Timer model: loads on the low-byte write, then fires irqs every tm_gap cycles.
    bit tm_set_ok = 1'b1;
    int tm_gap = 6, tm_per_load = 1, tm_left = 0, tm_cnt = 0;
    bit tm_fired = 1'b0;
    initial begin
        timer_irq = 1'b0;
        timer_counter_set = 1'b0;
        forever begin
            @(negedge clk);
            if (tm_fired) begin timer_irq = 1'b0; tm_fired = 1'b0; end
            if (reset || timer_rst) begin
                timer_counter_set = 1'b0;
                tm_left = 0;
            end else if (timer_we && timer_addr == 2'b10) begin
                timer_counter_set = tm_set_ok;
                tm_left = tm_set_ok ? tm_per_load : 0;
                tm_cnt = 0;
            end else if (timer_counter_set && tm_left > 0) begin
                tm_cnt++;
                if (tm_cnt == tm_gap) begin
                    timer_irq = 1'b1;
                    tm_fired = 1'b1;
                    tm_left--;
                    tm_cnt = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic [N-1:0] prev_grant = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (timer_we) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", {22'b0, timer_addr, timer_data}, 32'hFFFF_FFFF);
                else chk("wr", {22'b0, timer_addr, timer_data}, {22'b0, exp_wr.pop_front()});
                chk("we_rst_excl", {31'b0, timer_rst}, 32'd0);
            end
            if (done != '0) begin
                if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else chk("done", 32'(done), 32'(exp_done.pop_front()));
                chk("done_onehot", $countones(done), 32'd1);
            end
            if (cfg_err) begin
                if (exp_err.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
                else chk("cfg_err", {31'b0, cfg_err}, {31'b0, exp_err.pop_front()});
            end
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant.size() == 0) chk("grant_unexpected", 32'(grant), 32'd0);
                else chk("grant", 32'(grant), 32'(exp_grant.pop_front()));
            end
            prev_grant = grant;
        end
    end

    task automatic set_cnt(input int i, input logic [15:0] v);
        req_count[16*i +: 16] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; req_divider = '0; req_repeat = '0; timer_irq = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_wr(input logic [1:0] a);
        bit seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (timer_we && timer_addr == a) seen = 1'b1;
        end
        if (!seen) chk("wr_timeout", {30'b0, a}, 32'hFFFF_FFFF);
    endtask

    logic [N-1:0] t2_g[5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0]   t2_cfg[5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
    logic [15:0]  t2_cnt[5] = '{16'h10A0, 16'h20A1, 16'h30A2, 16'h40A3, 16'h10A0};

    initial begin
        int k;
        bit hit;
        reset = 1'b1; req = '0; req_count = '0; req_divider = '0; req_repeat = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_trst", {31'b0, timer_rst}, 0);
        chk("rst_we", {31'b0, timer_we}, 0);
        chk("rst_data", {22'b0, timer_addr, timer_data}, 0);
        chk("rst_err", {31'b0, cfg_err}, 0);
        reset = 1'b0;

        // Single one-shot load; payload change after grant must be ignored.
        set_cnt(0, 16'h0005); req = 4'b0001;
        push_load(4'b0001, 8'h00, 16'h0005);
        exp_done.push_back(4'b0001);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'b0001);
        chk("t1_clear_rst", {31'b0, timer_rst}, 1);
        chk("t1_clear_we", {31'b0, timer_we}, 0);
        chk("t1_busy", {31'b0, busy}, 1);
        set_cnt(0, 16'hFFFF);
        wait_done();
        chk("t1_rel_rst", {31'b0, timer_rst}, 1);
        chk("t1_rel_grant", 32'(grant), 0);
        req = '0;
        @(negedge clk);
        chk("t1_idle_busy", {31'b0, busy}, 0);

        // Round robin with all four requesting.
        do_reset();
        for (int i = 0; i < 4; i++) set_cnt(i, t2_cnt[i]);
        req_divider = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            push_load(t2_g[i], t2_cfg[i], t2_cnt[i]);
            exp_done.push_back(t2_g[i]);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_done();
        req = '0;
        @(negedge clk);
        chk("t2_idle_busy", {31'b0, busy}, 0);

        // Repeating owner: three irqs then withdrawal.
        do_reset();
        tm_per_load = 3;
        set_cnt(2, 16'h0203); req_repeat = 4'b0100;
        push_load(4'b0100, 8'h40, 16'h0203);
        repeat (3) exp_done.push_back(4'b0100);
        req = 4'b0100;
        for (int i = 0; i < 3; i++) wait_done();
        repeat (3) @(negedge clk);
        chk("t3_still_armed", {31'b0, busy}, 1);
        chk("t3_still_grant", 32'(grant), 32'b0100);
        req = '0;
        @(negedge clk);
        chk("t3_rel_rst", {31'b0, timer_rst}, 1);
        chk("t3_rel_grant", 32'(grant), 0);
        @(negedge clk);
        chk("t3_idle_busy", {31'b0, busy}, 0);
        repeat (8) @(negedge clk);

        // Load timeout.
        do_reset();
        tm_set_ok = 1'b0; tm_per_load = 1;
        set_cnt(1, 16'hABCD); req_divider = 4'b0010;
        push_load(4'b0010, 8'h80, 16'hABCD);
        exp_err.push_back(1'b1);
        req = 4'b0010;
        wait_wr(2'b10);
        k = 0; hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(negedge clk);
            k++;
            if (cfg_err) hit = 1'b1;
        end
        chk("t4_err_delay", k, TO + 1);
        chk("t4_err_rst", {31'b0, timer_rst}, 1);
        chk("t4_err_grant", 32'(grant), 0);
        chk("t4_err_done", 32'(done), 0);
        req = '0;
        @(negedge clk);
        chk("t4_err_once", {31'b0, cfg_err}, 0);
        chk("t4_idle_busy", {31'b0, busy}, 0);

        // irq and withdrawal in the same ARMED cycle; zero count passes through.
        do_reset();
        tm_set_ok = 1'b1; tm_per_load = 0;
        set_cnt(0, 16'h0000); req_repeat = 4'b0001;
        push_load(4'b0001, 8'h40, 16'h0000);
        exp_done.push_back(4'b0001);
        req = 4'b0001;
        wait_wr(2'b10);
        @(negedge clk); @(negedge clk);
        timer_irq = 1'b1; req = '0;
        @(negedge clk);
        timer_irq = 1'b0;
        chk("t5_done", 32'(done), 32'b0001);
        chk("t5_rel_rst", {31'b0, timer_rst}, 1);
        chk("t5_rel_grant", 32'(grant), 0);
        @(negedge clk);
        chk("t5_idle_busy", {31'b0, busy}, 0);
        chk("t5_no_done", 32'(done), 0);

        // Reset during the high-byte write.
        do_reset();
        tm_per_load = 1;
        set_cnt(3, 16'h1234); req_divider = 4'b1000; req_repeat = 4'b1000;
        exp_grant.push_back(4'b1000);
        exp_wr.push_back({2'b00, 8'hC0});
        exp_wr.push_back({2'b01, 8'h12});
        req = 4'b1000;
        wait_wr(2'b01);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_grant", 32'(grant), 0);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_we", {31'b0, timer_we}, 0);
        chk("t6_trst", {31'b0, timer_rst}, 0);
        chk("t6_data", {22'b0, timer_addr, timer_data}, 0);
        chk("t6_done_err", {27'b0, cfg_err, done}, 0);
        reset = 1'b0; req = '0;
        repeat (3) @(negedge clk);
        chk("t6_idle", {31'b0, busy}, 0);

        chk("q_wr_left", exp_wr.size(), 0);
        chk("q_grant_left", exp_grant.size(), 0);
        chk("q_done_left", exp_done.size(), 0);
        chk("q_err_left", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
